mem_port_arbiter: RTL and testbench

Single-port memory arbiter and sequencer that shares one unified instruction/data memory between the pipeline's fetch stage and its memory (load/store) stage. It accepts valid/ready requests from both requesters and issues at most one memory access at a time. It tracks the fixed memory latency and returns each response to the requester that issued it. Fetch responses that a pipeline redirect has made stale are dropped. The block sits between the fetch/memory stages of `pipelined_proc` and the memory array.

---
 rtl/mem_port_arbiter.sv | 126 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter: shares one memory between fetch and load/store,
// one access in flight, fixed read latency, and stale fetch responses are dropped on redirect.
module mem_port_arbiter #(
    parameter int ADDR_W     = 8,
    parameter int MEM_LAT    = 1,
    parameter int STREAK_MAX = 4
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              if_req_valid,
    input  logic [ADDR_W-1:0] if_req_addr,
    output logic              if_req_ready,
    input  logic              if_flush,
    output logic              if_resp_valid,
    output logic [31:0]       if_resp_data,

    input  logic              d_req_valid,
    input  logic              d_req_we,
    input  logic [3:0]        d_req_be,
    input  logic [ADDR_W-1:0] d_req_addr,
    input  logic [31:0]       d_req_wdata,
    output logic              d_req_ready,
    output logic              d_resp_valid,
    output logic [31:0]       d_resp_data,

    output logic              mem_en,
    output logic              mem_we,
    output logic [3:0]        mem_be,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,

    output logic              busy
);

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    localparam logic [3:0] STREAK_LIM = STREAK_MAX[3:0];
    localparam logic [2:0] LAT_LIM    = MEM_LAT[2:0];

    state_t     state;
    logic [3:0] streak;
    logic [2:0] lat_cnt;
    logic       owner_d;
    logic       owner_we;
    logic       killed;

    logic       in_idle;
    logic       fetch_wins;
    logic       grant_f;
    logic       grant_d;

    // Grants are gated by reset so nothing is issued while the block is being reset.
    assign in_idle    = (state == IDLE) && !reset;
    assign fetch_wins = if_req_valid && (!d_req_valid || (streak == STREAK_LIM));
    assign grant_f    = in_idle && fetch_wins;
    assign grant_d    = in_idle && d_req_valid && !fetch_wins;

    assign if_req_ready = grant_f;
    assign d_req_ready  = grant_d;
    assign mem_en       = grant_f || grant_d;
    assign mem_we       = grant_d && d_req_we;
    assign mem_be       = grant_d ? d_req_be : 4'b0000;
    assign mem_wdata    = grant_d ? d_req_wdata : 32'h0;
    assign mem_addr     = grant_d ? d_req_addr :
                          grant_f ? if_req_addr : '0;
    assign busy         = (state == WAIT);

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            streak        <= 4'd0;
            lat_cnt       <= 3'd0;
            owner_d       <= 1'b0;
            owner_we      <= 1'b0;
            killed        <= 1'b0;
            if_resp_valid <= 1'b0;
            if_resp_data  <= 32'h0;
            d_resp_valid  <= 1'b0;
            d_resp_data   <= 32'h0;
        end else begin
            if_resp_valid <= 1'b0;
            d_resp_valid  <= 1'b0;
            case (state)
                IDLE: begin
                    if (mem_en) begin
                        state    <= WAIT;
                        lat_cnt  <= 3'd1;
                        owner_d  <= grant_d;
                        owner_we <= grant_d && d_req_we;
                        killed   <= grant_f && if_flush;
                        if (grant_f) begin
                            streak <= 4'd0;
                        end else if (if_req_valid && (streak != STREAK_LIM)) begin
                            streak <= streak + 4'd1;
                        end
                    end
                end
                WAIT: begin
                    if (if_flush) begin
                        killed <= 1'b1;
                    end
                    if (lat_cnt == LAT_LIM) begin
                        state <= IDLE;
                        if (owner_d) begin
                            d_resp_valid <= 1'b1;
                            d_resp_data  <= owner_we ? 32'h0 : mem_rdata;
                        end else if (!(killed || if_flush)) begin
                            // A flush in the final wait cycle still kills the fetch.
                            if_resp_valid <= 1'b1;
                            if_resp_data  <= mem_rdata;
                        end
                    end else begin
                        lat_cnt <= lat_cnt + 3'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a latency-accurate memory model and a
// scoreboard of expected responses keyed by the cycle they are due.
module tb_mem_port_arbiter;

    localparam int AW   = 8;
    localparam int LAT  = 2;
    localparam int SMAX = 2;

    logic          clk;
    logic          reset;
    logic          if_req_valid;
    logic [AW-1:0] if_req_addr;
    logic          if_req_ready;
    logic          if_flush;
    logic          if_resp_valid;
    logic [31:0]   if_resp_data;
    logic          d_req_valid;
    logic          d_req_we;
    logic [3:0]    d_req_be;
    logic [AW-1:0] d_req_addr;
    logic [31:0]   d_req_wdata;
    logic          d_req_ready;
    logic          d_resp_valid;
    logic [31:0]   d_resp_data;
    logic          mem_en;
    logic          mem_we;
    logic [3:0]    mem_be;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata;
    logic          busy;

    mem_port_arbiter #(.ADDR_W(AW), .MEM_LAT(LAT), .STREAK_MAX(SMAX)) dut (
        .clk(clk), .reset(reset),
        .if_req_valid(if_req_valid), .if_req_addr(if_req_addr), .if_req_ready(if_req_ready),
        .if_flush(if_flush), .if_resp_valid(if_resp_valid), .if_resp_data(if_resp_data),
        .d_req_valid(d_req_valid), .d_req_we(d_req_we), .d_req_be(d_req_be),
        .d_req_addr(d_req_addr), .d_req_wdata(d_req_wdata), .d_req_ready(d_req_ready),
        .d_resp_valid(d_resp_valid), .d_resp_data(d_resp_data),
        .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] pat(input logic [7:0] a);
        return (a == 8'h10) ? 32'hDEADBEEF : {~a, a, 8'h3C, a ^ 8'hA5};
    endfunction

    // Memory model: byte-enabled writes, reads valid exactly LAT cycles after mem_en.
    logic [31:0] mem_model [256];
    logic        pv [1:LAT];
    logic [31:0] pd [1:LAT];

    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 256; i++) mem_model[i] <= pat(i[7:0]);
            for (int i = 1; i <= LAT; i++) pv[i] <= 1'b0;
        end else begin
            if (mem_en && mem_we) begin
                for (int b = 0; b < 4; b++)
                    if (mem_be[b]) mem_model[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
            end
            pv[1] <= mem_en && !mem_we;
            pd[1] <= mem_model[mem_addr];
            for (int i = 2; i <= LAT; i++) begin
                pv[i] <= pv[i-1];
                pd[i] <= pd[i-1];
            end
        end
    end

    assign mem_rdata = pv[LAT] ? pd[LAT] : 32'hBAD0BAD0;

    typedef struct {
        bit          is_d;
        logic [31:0] data;
        bit          killed;
        int          due;
    } exp_t;

    exp_t pend [$];
    bit   glog [$];
    int   n_cmp;
    int   n_bad;
    bit   done;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 20; i++) begin
            if (!busy) break;
            tick(1);
        end
        chk("idle_timeout", {63'd0, busy}, 64'd0);
    endtask

    initial begin
        int   s;
        bit   exp_g [6];
        reset = 1'b1; if_req_valid = 0; if_req_addr = '0; if_flush = 0;
        d_req_valid = 0; d_req_we = 0; d_req_be = 0; d_req_addr = '0; d_req_wdata = 0;
        n_cmp = 0; n_bad = 0; done = 0;
        fork
            begin : monitor
                int   cyc;
                exp_t e;
                cyc = 0;
                while (!done) begin
                    @(negedge clk);
                    cyc++;
                    if (reset) begin
                        pend.delete();
                    end else begin
                        if (pend.size() > 0 && pend[0].due == cyc) begin
                            e = pend.pop_front();
                            chk("d_resp_valid", {63'd0, d_resp_valid}, {63'd0, e.is_d});
                            chk("if_resp_valid", {63'd0, if_resp_valid}, {63'd0, !e.is_d && !e.killed});
                            if (e.is_d) chk("d_resp_data", {32'd0, d_resp_data}, {32'd0, e.data});
                            else if (!e.killed) chk("if_resp_data", {32'd0, if_resp_data}, {32'd0, e.data});
                        end else begin
                            chk("no_resp", {62'd0, d_resp_valid, if_resp_valid}, 64'd0);
                        end
                        if (pend.size() > 0 && !pend[0].is_d && if_flush) pend[0].killed = 1;
                        chk("busy", {63'd0, busy}, {63'd0, pend.size() != 0});
                        if (mem_en) begin
                            chk("one_ready", {63'd0, if_req_ready ^ d_req_ready}, 64'd1);
                            e.is_d   = d_req_ready;
                            e.data   = mem_we ? 32'h0 : mem_model[mem_addr];
                            e.killed = if_req_ready && if_flush;
                            e.due    = cyc + LAT + 1;
                            pend.push_back(e);
                            glog.push_back(d_req_ready);
                        end else begin
                            chk("mem_idle_zero", {19'd0, mem_we, mem_be, mem_addr, mem_wdata}, 64'd0);
                        end
                    end
                end
            end
            begin : stimulus
                tick(3);
                chk("rst_if_ready", {63'd0, if_req_ready}, 64'd0);
                chk("rst_d_ready", {63'd0, d_req_ready}, 64'd0);
                chk("rst_mem_en", {63'd0, mem_en}, 64'd0);
                chk("rst_busy", {63'd0, busy}, 64'd0);
                chk("rst_resp_valid", {62'd0, if_resp_valid, d_resp_valid}, 64'd0);
                chk("rst_resp_data", {if_resp_data, d_resp_data}, 64'd0);
                reset = 1'b0;
                tick(1);

                // lone load
                d_req_valid = 1; d_req_addr = 8'h10; #1;
                chk("load_ready", {63'd0, d_req_ready}, 64'd1);
                chk("load_mem_en", {63'd0, mem_en}, 64'd1);
                chk("load_addr", {56'd0, mem_addr}, 64'h10);
                tick(1); d_req_valid = 0;
                chk("wait_ready", {62'd0, d_req_ready, if_req_ready}, 64'd0);
                wait_idle();
                chk("load_data", {32'd0, d_resp_data}, 64'hDEADBEEF);

                // store then load back
                tick(1);
                d_req_valid = 1; d_req_we = 1; d_req_be = 4'b0011; d_req_addr = 8'h20;
                d_req_wdata = 32'h12345678; #1;
                chk("st_we", {63'd0, mem_we}, 64'd1);
                chk("st_be", {60'd0, mem_be}, 64'h3);
                chk("st_wdata", {32'd0, mem_wdata}, 64'h12345678);
                tick(1); d_req_valid = 0; d_req_we = 0;
                wait_idle();
                chk("st_resp", {31'd0, d_resp_valid, d_resp_data}, 64'h1_0000_0000);
                d_req_valid = 1; d_req_be = 4'b0000; #1;
                tick(1); d_req_valid = 0;
                wait_idle();
                chk("st_merge", {32'd0, d_resp_data}, 64'hDF205678);

                // contention: D, D, F, D, D, F
                tick(1);
                s = glog.size();
                exp_g = '{1, 1, 0, 1, 1, 0};
                if_req_valid = 1; if_req_addr = 8'h30;
                d_req_valid = 1; d_req_addr = 8'h40;
                tick(16);
                if_req_valid = 0; d_req_valid = 0;
                wait_idle();
                chk("grant_count", 64'(glog.size() - s), 64'd6);
                for (int i = 0; i < 6; i++)
                    if (s + i < glog.size())
                        chk("grant_order", {63'd0, glog[s+i]}, {63'd0, exp_g[i]});

                // flush one cycle after issue, then a normal fetch
                tick(1);
                if_req_valid = 1; if_req_addr = 8'h50; #1;
                chk("f_ready", {63'd0, if_req_ready}, 64'd1);
                tick(1); if_req_valid = 0; if_flush = 1;
                tick(1); if_flush = 0;
                tick(1);
                chk("killed_resp", {63'd0, if_resp_valid}, 64'd0);
                if_req_valid = 1; if_req_addr = 8'h51; #1;
                chk("f2_ready", {63'd0, if_req_ready}, 64'd1);
                tick(1); if_req_valid = 0;
                tick(2);
                chk("f2_resp", {31'd0, if_resp_valid, if_resp_data}, {31'd0, 1'b1, pat(8'h51)});

                // flush in the issue cycle kills; flush during a load is ignored
                tick(1);
                if_req_valid = 1; if_flush = 1; if_req_addr = 8'h52;
                tick(1); if_req_valid = 0; if_flush = 0;
                wait_idle();
                chk("f3_killed", {63'd0, if_resp_valid}, 64'd0);
                d_req_valid = 1; d_req_addr = 8'h60; if_flush = 1;
                tick(1); d_req_valid = 0;
                wait_idle();
                if_flush = 0;
                chk("d_flush_resp", {31'd0, d_resp_valid, d_resp_data}, {31'd0, 1'b1, pat(8'h60)});

                // reset mid-transaction
                tick(1);
                d_req_valid = 1; d_req_addr = 8'h70;
                tick(1); d_req_valid = 0; reset = 1;
                tick(1); reset = 0;
                chk("rst_abort_busy", {63'd0, busy}, 64'd0);
                tick(4);
                d_req_valid = 1; d_req_addr = 8'h71; #1;
                chk("post_rst_ready", {63'd0, d_req_ready}, 64'd1);
                tick(1); d_req_valid = 0;
                wait_idle();
                chk("post_rst_resp", {31'd0, d_resp_valid, d_resp_data}, {31'd0, 1'b1, pat(8'h71)});
                tick(3);
                chk("drained", 64'(pend.size()), 64'd0);
                done = 1;
            end
        join
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
